// File: rtl/phase_scheduler.sv
// phase_scheduler: registered signal-phase sequencer for a four-way intersection.
// Chooses the approach (N/E/S/W) that holds green, runs the pedestrian walk
// phase, and lets emergency vehicles preempt the normal rotation.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   sensor     queue density 0..3 per approach, N=[1:0] E=[3:2] S=[5:4] W=[7:6]
//   ped_req    pedestrian requests, bit0=N .. bit3=W
//   emergency  emergency vehicle present (level), same bit order
//   green      per-approach green lamps (one-hot or zero)
//   yellow     per-approach yellow lamps (one-hot or zero)
//   red        per-approach red lamps, ~(green|yellow)
//   walk       walk lamps, nonzero only in WALK
//   phase      ALL_RED=0, GREEN=1, YELLOW=2, WALK=3, EMERG=4
module phase_scheduler #(
    parameter int unsigned GREEN_BASE = 8,
    parameter int unsigned GREEN_EXT  = 4,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 2,
    parameter int unsigned WALK_T     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sensor,
    input  logic [3:0] ped_req,
    input  logic [3:0] emergency,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [3:0] walk,
    output logic [2:0] phase
);

    localparam int unsigned TIMER_W = 8;
    localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LOAD   = TIMER_W'(WALK_T - 1);

    typedef enum logic [2:0] {
        PH_ALL_RED = 3'd0,
        PH_GREEN   = 3'd1,
        PH_YELLOW  = 3'd2,
        PH_WALK    = 3'd3,
        PH_EMERG   = 3'd4
    } phase_e;

    phase_e               phase_q, phase_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [1:0]           cur_q, cur_d;
    logic [1:0]           last_q, last_d;
    logic [3:0][1:0]      age_q, age_d;
    logic [3:0]           ped_pend_q, ped_pend_d;
    logic                 last_walk_q, last_walk_d;
    logic [3:0]           walk_q, walk_d;
    logic [3:0]           green_q, green_d;
    logic [3:0]           yellow_q, yellow_d;
    logic [3:0]           red_q, red_d;

    logic [3:0][2:0]      score;
    logic [2:0]           best;
    logic [1:0]           sel;
    logic [3:0][1:0]      age_upd;
    logic [1:0]           em_idx;
    logic [TIMER_W-1:0]   green_load;

    // Vehicle selection: highest sensor+age, ties broken round-robin from last+1.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            score[i] = {1'b0, sensor[2*i +: 2]} + {1'b0, age_q[i]};
        end
        sel  = last_q + 2'd1;
        best = score[sel];
        for (int k = 1; k < 4; k++) begin
            if (score[last_q + 2'd1 + 2'(k)] > best) begin
                sel  = last_q + 2'd1 + 2'(k);
                best = score[sel];
            end
        end
        // Served approach restarts aging; waiting queues age up to 3.
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == sel) begin
                age_upd[i] = 2'd0;
            end else if (sensor[2*i +: 2] != 2'd0 && age_q[i] != 2'd3) begin
                age_upd[i] = age_q[i] + 2'd1;
            end else begin
                age_upd[i] = age_q[i];
            end
        end
        green_load = TIMER_W'(GREEN_BASE) - TIMER_W'(1)
                   + TIMER_W'(GREEN_EXT) * {6'd0, sensor[{sel, 1'b0} +: 2]};
    end

    // Lowest-index emergency wins (N > E > S > W).
    always_comb begin
        em_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (emergency[i]) begin
                em_idx = 2'(i);
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        phase_d     = phase_q;
        timer_d     = timer_q;
        cur_d       = cur_q;
        last_d      = last_q;
        age_d       = age_q;
        ped_pend_d  = ped_pend_q | ped_req;
        last_walk_d = last_walk_q;
        walk_d      = walk_q;

        case (phase_q)
            PH_ALL_RED: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (|emergency) begin
                    phase_d = PH_EMERG;
                    cur_d   = em_idx;
                    timer_d = '0;
                end else if (|ped_pend_q && !last_walk_q) begin
                    // Requests arriving on this edge stay pending for the next walk.
                    phase_d     = PH_WALK;
                    walk_d      = ped_pend_q;
                    ped_pend_d  = ped_req;
                    timer_d     = WALK_LOAD;
                    last_walk_d = 1'b1;
                end else begin
                    phase_d     = PH_GREEN;
                    cur_d       = sel;
                    last_d      = sel;
                    age_d       = age_upd;
                    timer_d     = green_load;
                    last_walk_d = 1'b0;
                end
            end
            PH_GREEN: begin
                if (emergency[cur_q]) begin
                    phase_d = PH_EMERG;
                    timer_d = '0;
                end else if (|emergency || timer_q == '0) begin
                    phase_d = PH_YELLOW;
                    timer_d = YELLOW_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            PH_YELLOW: begin
                if (timer_q == '0) begin
                    phase_d = PH_ALL_RED;
                    timer_d = ALLRED_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            PH_WALK: begin
                if (|emergency || timer_q == '0) begin
                    phase_d = PH_ALL_RED;
                    timer_d = ALLRED_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            PH_EMERG: begin
                if (!emergency[cur_q]) begin
                    phase_d = PH_YELLOW;
                    timer_d = YELLOW_LOAD;
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                timer_d = ALLRED_LOAD;
            end
        endcase

        if (phase_d != PH_WALK) begin
            walk_d = '0;
        end
        green_d  = (phase_d == PH_GREEN || phase_d == PH_EMERG) ? (4'b0001 << cur_d) : 4'b0000;
        yellow_d = (phase_d == PH_YELLOW) ? (4'b0001 << cur_d) : 4'b0000;
        red_d    = ~(green_d | yellow_d);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q     <= PH_ALL_RED;
            timer_q     <= ALLRED_LOAD;
            cur_q       <= 2'd3;
            last_q      <= 2'd3;
            age_q       <= '0;
            ped_pend_q  <= '0;
            last_walk_q <= 1'b0;
            walk_q      <= '0;
            green_q     <= '0;
            yellow_q    <= '0;
            red_q       <= 4'hF;
        end else begin
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            age_q       <= age_d;
            ped_pend_q  <= ped_pend_d;
            last_walk_q <= last_walk_d;
            walk_q      <= walk_d;
            green_q     <= green_d;
            yellow_q    <= yellow_d;
            red_q       <= red_d;
        end
    end

    assign green  = green_q;
    assign yellow = yellow_q;
    assign red    = red_q;
    assign walk   = walk_q;
    assign phase  = phase_q;

endmodule
